// File: rtl/spi_master_pkg.sv
// -----------------------------------------------------------------------------
// spi_master_pkg
// Shared definitions for the parametrised SPI master:
//   - spi_state_e      : frame sequencing states (IDLE, SETUP, XFER, HOLD, GAP)
//   - SPI_MODE0..3     : SPI mode encodings as {cpol, cpha}
//   - SCLK_IDLE_DEFAULT: SCLK level (and latched cpol) coming out of reset
//   - width_for()      : counter width needed to count 0..n-1 (never below 1)
// -----------------------------------------------------------------------------
package spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam logic SCLK_IDLE_DEFAULT = 1'b0;

    // Bits needed for a counter running 0..n-1; a 1-bit counter is the floor
    // so that n=1 still yields a legal vector.
    function automatic int unsigned width_for(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// -----------------------------------------------------------------------------
// spi_clk_div
// SCLK half-period timer. Runs only while en_i is high and restarts from zero
// every time it is enabled, so the first edge of a frame is always a full
// half-period after XFER entry.
// Ports:
//   clk_i      in   system clock
//   rstn_i     in   asynchronous active-low reset
//   en_i       in   count enable (high during XFER)
//   tick_o     out  one-cycle strobe: an SCLK edge happens on this clock edge
//   leading_o  out  1 when the pending edge is a leading edge, 0 for trailing
// -----------------------------------------------------------------------------
module spi_clk_div
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = 20
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic en_i,
    output logic tick_o,
    output logic leading_o
);

    localparam int CNT_W = width_for(CLK_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic             r_trail;
    logic             w_term;

    assign w_term    = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign tick_o    = en_i && w_term;
    assign leading_o = ~r_trail;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt   <= '0;
            r_trail <= 1'b0;
        end else if (!en_i) begin
            // Parked at zero so each frame starts on a leading edge.
            r_cnt   <= '0;
            r_trail <= 1'b0;
        end else if (w_term) begin
            r_cnt   <= '0;
            r_trail <= ~r_trail;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// -----------------------------------------------------------------------------
// spi_master_param
// Parametrised single-slave SPI master: programmable frame length (1..DATA_W
// bits, MSB first), all four SPI modes, full-duplex shifting, start/ready
// handshake and a one-cycle rx_valid_o pulse when the received word updates.
//
// Parameters:
//   DATA_W          maximum frame length / data port width (>= 2)
//   CLK_DIV         SCLK half-period in clk_i cycles (>= 1)
//   CS_IDLE_CYCLES  cycles spi_cs_n_o stays high between frames (>= 1)
//
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   start_i/ready_o frame request / idle handshake
//   tx_data_i       transmit word (right-aligned), captured at acceptance
//   len_i           frame length minus one (clamped to DATA_W-1)
//   cpol_i, cpha_i  SPI mode, captured at acceptance
//   rx_data_o       received word, right-aligned, upper bits zero
//   rx_valid_o      one-cycle pulse when rx_data_o is loaded
//   spi_clk_o, spi_mosi_o, spi_miso_i, spi_cs_n_o   SPI pins
//
// Optional feature (macro SPI_MASTER_LOOPBACK_EN): adds loopback_i, captured at
// acceptance; when set, MISO samples come from the internal MOSI driver.
//
// Frame timeline (acceptance edge = cycle 0):
//   SETUP CLK_DIV cycles, XFER 2*(len+1) half-periods with an SCLK edge at the
//   end of each, HOLD CLK_DIV cycles, then GAP. ready_o is already high in the
//   final GAP cycle so back-to-back frames see exactly CS_IDLE_CYCLES of cs_n
//   high.
// -----------------------------------------------------------------------------
module spi_master_param
    import spi_master_pkg::*;
#(
    parameter int   DATA_W         = 8,
    parameter int   CLK_DIV        = 20,
    parameter int   CS_IDLE_CYCLES = 2,
    localparam int  LEN_W          = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic              loopback_i,
`endif
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              spi_clk_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i,
    output logic              spi_cs_n_o
);

    localparam int CNT_MAX = (CLK_DIV > CS_IDLE_CYCLES) ? CLK_DIV : CS_IDLE_CYCLES;
    localparam int CNT_W   = width_for(CNT_MAX);
    localparam int EDGE_W  = LEN_W + 1;

    // ---------------------------------------------------------------- state
    spi_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len;
    logic              r_cpol;
    logic              r_cpha;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_rx_sh;
    logic [EDGE_W-1:0] r_edge_cnt;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_cs_n;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic              r_loop;
`endif

    // ---------------------------------------------------------------- wires
    logic [31:0]       w_len_ext;
    logic [LEN_W-1:0]  w_len;
    logic [LEN_W-1:0]  w_shamt;
    logic [DATA_W-1:0] w_tx_aligned;
    logic              w_setup_done;
    logic              w_hold_done;
    logic              w_gap_done;
    logic              w_accept;
    logic              w_last_edge;
    logic              w_miso_bit;
    logic              w_div_en;
    logic              w_tick;
    logic              w_leading;

    // Out-of-range lengths (possible only when DATA_W is not a power of two)
    // are clamped to a full-width frame.
    assign w_len_ext = 32'(len_i);
    assign w_len     = (w_len_ext > 32'(DATA_W - 1)) ? LEN_W'(DATA_W - 1) : len_i;

    // Left-justify the frame so the bit to send next is always the MSB of the
    // shift register; bits above len fall off the top.
    assign w_shamt      = LEN_W'(DATA_W - 1) - w_len;
    assign w_tx_aligned = tx_data_i << w_shamt;

    assign w_setup_done = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_hold_done  = (r_cnt == CNT_W'(CLK_DIV - 1));
    assign w_gap_done   = (r_cnt == CNT_W'(CS_IDLE_CYCLES - 1));

    assign ready_o  = (r_state == ST_IDLE) || ((r_state == ST_GAP) && w_gap_done);
    assign w_accept = start_i && ready_o;

    // Edge indices run 0..2*len+1; the final one is always a trailing edge.
    assign w_last_edge = (r_edge_cnt == {r_len, 1'b1});

`ifdef SPI_MASTER_LOOPBACK_EN
    assign w_miso_bit = r_loop ? r_mosi : spi_miso_i;
`else
    assign w_miso_bit = spi_miso_i;
`endif

    assign w_div_en = (r_state == ST_XFER);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .en_i      (w_div_en),
        .tick_o    (w_tick),
        .leading_o (w_leading)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_cpol     <= SCLK_IDLE_DEFAULT;
            r_cpha     <= 1'b0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_edge_cnt <= '0;
            r_sclk     <= SCLK_IDLE_DEFAULT;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
            r_loop     <= 1'b0;
`endif
        end else begin
            r_rx_valid <= 1'b0;

            if (w_accept) begin
                r_state    <= ST_SETUP;
                r_cnt      <= '0;
                r_len      <= w_len;
                r_cpol     <= cpol_i;
                r_cpha     <= cpha_i;
                r_sclk     <= cpol_i;
                r_cs_n     <= 1'b0;
                r_edge_cnt <= '0;
                r_rx_sh    <= '0;
`ifdef SPI_MASTER_LOOPBACK_EN
                r_loop     <= loopback_i;
`endif
                if (cpha_i) begin
                    // First bit goes out on the first leading edge.
                    r_mosi  <= 1'b0;
                    r_tx_sh <= w_tx_aligned;
                end else begin
                    // First bit must be valid as soon as cs_n falls.
                    r_mosi  <= w_tx_aligned[DATA_W-1];
                    r_tx_sh <= w_tx_aligned << 1;
                end
            end else begin
                case (r_state)
                    ST_SETUP: begin
                        if (w_setup_done) begin
                            r_state <= ST_XFER;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end

                    ST_XFER: begin
                        if (w_tick) begin
                            r_sclk     <= ~r_sclk;
                            r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
                            // Launch on one edge type, capture on the other;
                            // which is which depends on the latched cpha.
                            if (w_leading == r_cpha) begin
                                if (r_cpha || !w_last_edge) begin
                                    r_mosi  <= r_tx_sh[DATA_W-1];
                                    r_tx_sh <= r_tx_sh << 1;
                                end
                            end else begin
                                r_rx_sh <= {r_rx_sh[DATA_W-2:0], w_miso_bit};
                            end
                            if (w_last_edge) begin
                                r_state <= ST_HOLD;
                                r_cnt   <= '0;
                            end
                        end
                    end

                    ST_HOLD: begin
                        if (w_hold_done) begin
                            r_state    <= ST_GAP;
                            r_cnt      <= '0;
                            r_cs_n     <= 1'b1;
                            r_mosi     <= 1'b0;
                            r_rx_data  <= r_rx_sh;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end

                    ST_GAP: begin
                        if (w_gap_done) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_data_o  = r_rx_data;
    assign rx_valid_o = r_rx_valid;
    assign spi_clk_o  = r_sclk;
    assign spi_mosi_o = r_mosi;
    assign spi_cs_n_o = r_cs_n;

endmodule

// File: tb/tb_spi_master_param.sv
// -----------------------------------------------------------------------------
// tb_spi_master_param
// Drives spi_master_param (DATA_W=8, CLK_DIV=2, CS_IDLE_CYCLES=2) with a table
// of directed frames, hand-written corner sequences and random frames. A
// behavioural SPI slave sitting on the pins supplies MISO bits and records the
// MOSI bits it sees; expected words come from tx/slave data masked to len+1.
// -----------------------------------------------------------------------------
module tb_spi_master_param;
    import spi_master_pkg::*;

    localparam int DW  = 8;
    localparam int CD  = 2;
    localparam int CSI = 2;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          start_i;
    logic          ready_o;
    logic [DW-1:0] tx_data_i;
    logic [2:0]    len_i;
    logic          cpol_i;
    logic          cpha_i;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic          loopback_i;
`endif
    logic [DW-1:0] rx_data_o;
    logic          rx_valid_o;
    logic          spi_clk_o;
    logic          spi_mosi_o;
    logic          spi_miso_i;
    logic          spi_cs_n_o;

    spi_master_param #(
        .DATA_W         (DW),
        .CLK_DIV        (CD),
        .CS_IDLE_CYCLES (CSI)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .start_i    (start_i),
        .ready_o    (ready_o),
        .tx_data_i  (tx_data_i),
        .len_i      (len_i),
        .cpol_i     (cpol_i),
        .cpha_i     (cpha_i),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback_i (loopback_i),
`endif
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .spi_clk_o  (spi_clk_o),
        .spi_mosi_o (spi_mosi_o),
        .spi_miso_i (spi_miso_i),
        .spi_cs_n_o (spi_cs_n_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ slave model
    logic       m_cpol = 1'b0;
    logic       m_cpha = 1'b0;
    int         m_len  = 0;
    logic [7:0] m_slave = 8'h00;
    logic       m_miso_zero = 1'b0;

    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_rv = 1'b0;
    int          sl_i = 0;
    int          edges = 0;
    int          mosi_word = 0;
    int          mosi_n = 0;
    int          fall_cnt = 0;
    int unsigned fall_cyc = 0;
    int unsigned rise_cyc = 0;
    int          gap_last = 0;
    logic        sclk_at_fall = 1'b0;
    int          rv_cnt = 0;
    int          rv_data = 0;
    int unsigned rv_cyc = 0;
    logic        rv_cs = 1'b0;
    int          rv_double = 0;

    function automatic logic slave_bit(input int i);
        if (m_miso_zero || i > m_len) return 1'b0;
        return m_slave[m_len - i];
    endfunction

    initial begin
        spi_miso_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (prev_cs && !spi_cs_n_o) begin
                fall_cnt++;
                gap_last     = int'(cyc - rise_cyc);
                fall_cyc     = cyc;
                sl_i         = 0;
                edges        = 0;
                mosi_word    = 0;
                mosi_n       = 0;
                sclk_at_fall = spi_clk_o;
                if (!m_cpha) spi_miso_i = slave_bit(0);
            end else if (!prev_cs && spi_cs_n_o) begin
                rise_cyc = cyc;
            end else if (!spi_cs_n_o && spi_clk_o != prev_sclk) begin
                edges++;
                if (spi_clk_o != m_cpol) begin          // leading edge
                    if (!m_cpha) begin
                        mosi_word = (mosi_word << 1) | int'(spi_mosi_o);
                        mosi_n++;
                    end else begin
                        spi_miso_i = slave_bit(sl_i);
                    end
                end else begin                          // trailing edge
                    if (!m_cpha) begin
                        sl_i++;
                        spi_miso_i = slave_bit(sl_i);
                    end else begin
                        mosi_word = (mosi_word << 1) | int'(spi_mosi_o);
                        mosi_n++;
                        sl_i++;
                    end
                end
            end
            if (rx_valid_o) begin
                if (prev_rv) rv_double++;
                rv_cnt++;
                rv_data = int'(rx_data_o);
                rv_cyc  = cyc;
                rv_cs   = spi_cs_n_o;
            end
            prev_rv   = rx_valid_o;
            prev_cs   = spi_cs_n_o;
            prev_sclk = spi_clk_o;
        end
    end

    // Step to just after the next falling edge (monitor has already run).
    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic set_mode(input logic [2:0] len, input logic [1:0] mode,
                            input logic [7:0] slave, input logic lb);
        m_len       = int'(len);
        m_cpol      = mode[1];
        m_cpha      = mode[0];
        m_slave     = slave;
        m_miso_zero = lb;
    endtask

    // One complete frame with all per-frame checks.
    task automatic run_frame(input int fno, input logic [7:0] tx, input logic [2:0] len,
                             input logic [1:0] mode, input logic [7:0] slave,
                             input logic [7:0] exp_rx, input logic lb);
        int          rv0;
        int          k;
        int unsigned acc;
        int          mask;
        rv0  = rv_cnt;
        mask = (1 << (int'(len) + 1)) - 1;
        k = 0;
        while (!ready_o && k < 500) begin tick(); k++; end
        set_mode(len, mode, slave, lb);
        tx_data_i = tx;
        len_i     = len;
        cpol_i    = mode[1];
        cpha_i    = mode[0];
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback_i = lb;
`endif
        start_i = 1'b1;
        tick();
        acc     = cyc;
        start_i = 1'b0;
        // Scramble the captured inputs; the frame must not notice.
        tx_data_i = 8'($urandom);
        len_i     = 3'($urandom);
        cpol_i    = 1'($urandom);
        cpha_i    = 1'($urandom);
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback_i = 1'($urandom);
`endif
        k = 0;
        while (rv_cnt == rv0 && k < 1000) begin tick(); k++; end
        check($sformatf("f%0d_cs_low_cycle", fno), int'(fall_cyc - acc) + 1, 1);
        check($sformatf("f%0d_rx_data", fno), rv_data, int'(exp_rx));
        check($sformatf("f%0d_rx_latency", fno), int'(rv_cyc - acc) + 1,
              1 + 2 * CD + 2 * CD * (int'(len) + 1));
        check($sformatf("f%0d_cs_at_valid", fno), int'(rv_cs), 1);
        check($sformatf("f%0d_mosi_bits", fno), mosi_word, int'(tx) & mask);
        check($sformatf("f%0d_mosi_count", fno), mosi_n, int'(len) + 1);
        check($sformatf("f%0d_sclk_edges", fno), edges, 2 * (int'(len) + 1));
        check($sformatf("f%0d_sclk_idle_setup", fno), int'(sclk_at_fall), int'(mode[1]));
        tick();
        tick();
        check($sformatf("f%0d_valid_pulses", fno), rv_cnt - rv0, 1);
        check($sformatf("f%0d_ready_back", fno), int'(ready_o), 1);
        check($sformatf("f%0d_mosi_idle", fno), int'(spi_mosi_o), 0);
        check($sformatf("f%0d_sclk_idle_after", fno), int'(spi_clk_o), int'(mode[1]));
        check($sformatf("f%0d_rx_hold", fno), int'(rx_data_o), int'(exp_rx));
        $display("frame %0d mode=%0d len=%0d tx=%02h slave=%02h rx=%02h exp=%02h",
                 fno, mode, len, tx, slave, rv_data, exp_rx);
    endtask

    typedef struct packed {
        logic [7:0] tx;
        logic [2:0] len;
        logic [1:0] mode;
        logic [7:0] slave;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [0:3];

    initial begin
        #200000;
        $display("FAIL watchdog no_finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          f0;
        int          r0;
        int          k;
        int unsigned acc;
        logic [7:0]  tx;
        logic [7:0]  sl;
        logic [2:0]  ln;
        logic [1:0]  md;

        vecs[0] = '{tx: 8'hA5, len: 3'd7, mode: SPI_MODE0, slave: 8'h3C, exp_rx: 8'h3C};
        vecs[1] = '{tx: 8'h0B, len: 3'd3, mode: SPI_MODE3, slave: 8'h06, exp_rx: 8'h06};
        vecs[2] = '{tx: 8'h01, len: 3'd0, mode: SPI_MODE1, slave: 8'hFF, exp_rx: 8'h01};
        vecs[3] = '{tx: 8'hF3, len: 3'd5, mode: SPI_MODE2, slave: 8'hEA, exp_rx: 8'h2A};

        rstn_i    = 1'b0;
        start_i   = 1'b0;
        tx_data_i = '0;
        len_i     = '0;
        cpol_i    = 1'b0;
        cpha_i    = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
        loopback_i = 1'b0;
`endif
        tick();
        tick();
        check("rst_ready", int'(ready_o), 1);
        check("rst_cs_n", int'(spi_cs_n_o), 1);
        check("rst_sclk", int'(spi_clk_o), 0);
        check("rst_mosi", int'(spi_mosi_o), 0);
        check("rst_rx_data", int'(rx_data_o), 0);
        check("rst_rx_valid", int'(rx_valid_o), 0);
        rstn_i = 1'b1;
        tick();

        // Directed table.
        for (int i = 0; i < 4; i++)
            run_frame(i, vecs[i].tx, vecs[i].len, vecs[i].mode, vecs[i].slave,
                      vecs[i].exp_rx, 1'b0);

        // start_i held high: one frame per acceptance, exact cs_n gap.
        set_mode(3'd7, SPI_MODE0, 8'h96, 1'b0);
        f0 = fall_cnt;
        r0 = rv_cnt;
        tx_data_i = 8'h5A;
        len_i     = 3'd7;
        cpol_i    = 1'b0;
        cpha_i    = 1'b0;
        start_i   = 1'b1;
        k = 0;
        while (fall_cnt < f0 + 2 && k < 500) begin
            tick();
            k++;
            if (fall_cnt == f0 + 1 && !spi_cs_n_o)
                check("b2b_busy_ready", int'(ready_o), 0);
        end
        start_i = 1'b0;
        k = 0;
        while (rv_cnt < r0 + 2 && k < 500) begin tick(); k++; end
        for (int j = 0; j < 6; j++) tick();
        check("b2b_frames", fall_cnt - f0, 2);
        check("b2b_valids", rv_cnt - r0, 2);
        check("b2b_cs_gap", gap_last, CSI);
        check("b2b_rx_data", rv_data, 32'h96);
        check("b2b_mosi_bits", mosi_word, 32'h5A);
        $display("frame b2b frames=%0d gap=%0d rx=%02h", fall_cnt - f0, gap_last, rv_data);

        // Reset in the middle of XFER.
        set_mode(3'd7, SPI_MODE3, 8'hC9, 1'b0);
        tx_data_i = 8'hFF;
        len_i     = 3'd7;
        cpol_i    = 1'b1;
        cpha_i    = 1'b1;
        start_i   = 1'b1;
        k = 0;
        while (spi_cs_n_o && k < 100) begin tick(); k++; end
        start_i = 1'b0;
        acc = cyc;
        while (cyc - acc < 14) tick();
        r0 = rv_cnt;
        check("mid_busy_cs", int'(spi_cs_n_o), 0);
        rstn_i = 1'b0;
        #1;
        check("mid_rst_cs_n", int'(spi_cs_n_o), 1);
        check("mid_rst_sclk", int'(spi_clk_o), 0);
        check("mid_rst_ready", int'(ready_o), 1);
        check("mid_rst_mosi", int'(spi_mosi_o), 0);
        check("mid_rst_rx_data", int'(rx_data_o), 0);
        tick();
        tick();
        rstn_i = 1'b1;
        for (int j = 0; j < 40; j++) tick();
        check("mid_rst_no_valid", rv_cnt - r0, 0);
        $display("frame reset_mid_xfer valids_after=%0d", rv_cnt - r0);
        run_frame(10, 8'h3D, 3'd7, SPI_MODE0, 8'hB4, 8'hB4, 1'b0);

`ifdef SPI_MASTER_LOOPBACK_EN
        run_frame(11, 8'hC3, 3'd7, SPI_MODE0, 8'h00, 8'hC3, 1'b1);
        run_frame(12, 8'h2D, 3'd6, SPI_MODE1, 8'h00, 8'h2D, 1'b1);
`endif

        // Random frames against the reference model.
        for (int i = 0; i < 24; i++) begin
            tx = 8'($urandom);
            sl = 8'($urandom);
            ln = 3'($urandom_range(0, 7));
            md = 2'($urandom_range(0, 3));
            run_frame(20 + i, tx, ln, md, sl,
                      8'(int'(sl) & ((1 << (int'(ln) + 1)) - 1)), 1'b0);
        end

        check("no_double_valid", rv_double, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
